thermo_led_pio: RTL and testbench



---
 rtl/thermo_led_pio.sv | 161 ++++++++++++++++
 tb/tb_thermo_led_pio.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_led_pio.sv
// thermo_led_pio: Avalon-MM LED peripheral with per-channel static, blink, PWM
// and blink+PWM modes driven by a shared prescaler, PWM counter and blink phase.
// Optional macro LED_SET_CLR_EN turns addresses 5/6 into DATA set/clear ports.
module thermo_led_pio #(
   parameter int unsigned NUM_LEDS         = 10,
   parameter int unsigned PWM_BITS         = 8,
   parameter int unsigned PRESCALE_W       = 16,
   parameter int unsigned DEFAULT_PRESCALE = 999
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [2:0]          avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic                avs_readdatavalid,
   output logic [NUM_LEDS-1:0] leds_export
);

   localparam int unsigned MODE_W = 2 * NUM_LEDS;

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_MODE  = 3'd1;
   localparam logic [2:0] ADDR_DUTY  = 3'd2;
   localparam logic [2:0] ADDR_PRE   = 3'd3;
   localparam logic [2:0] ADDR_LEDS  = 3'd4;
   localparam logic [2:0] ADDR_SET   = 3'd5;
   localparam logic [2:0] ADDR_CLR   = 3'd6;

   logic [NUM_LEDS-1:0]   data_q,        data_d;
   logic [MODE_W-1:0]     mode_q,        mode_d;
   logic [PWM_BITS-1:0]   duty_shadow_q, duty_shadow_d;
   logic [PWM_BITS-1:0]   duty_active_q, duty_active_d;
   logic [PRESCALE_W-1:0] prescale_q,    prescale_d;
   logic [PRESCALE_W-1:0] pre_cnt_q,     pre_cnt_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q,     pwm_cnt_d;
   logic                  blink_q,       blink_d;
   logic [NUM_LEDS-1:0]   leds_q,        leds_d;
   logic [31:0]           rdata_q,       rdata_d;
   logic                  rvalid_q,      rvalid_d;

   logic wr_data_c, wr_mode_c, wr_duty_c, wr_pre_c, wr_set_c, wr_clr_c;
   logic tick_c, wrap_c, pwm_on_c;
   logic unused_wdata;

   // Upper write-data bits beyond the widest register are intentionally dropped.
   assign unused_wdata = ^avs_writedata;

   // Write strobe decode.
   always_comb begin
      wr_data_c = avs_write && (avs_address == ADDR_DATA);
      wr_mode_c = avs_write && (avs_address == ADDR_MODE);
      wr_duty_c = avs_write && (avs_address == ADDR_DUTY);
      wr_pre_c  = avs_write && (avs_address == ADDR_PRE);
`ifdef LED_SET_CLR_EN
      wr_set_c  = avs_write && (avs_address == ADDR_SET);
      wr_clr_c  = avs_write && (avs_address == ADDR_CLR);
`else
      wr_set_c  = 1'b0;
      wr_clr_c  = 1'b0;
`endif
   end

   // Shared timebase: prescaler tick, PWM wrap and PWM comparator.
   always_comb begin
      tick_c   = (pre_cnt_q == prescale_q);
      wrap_c   = tick_c && (pwm_cnt_q == {PWM_BITS{1'b1}});
      pwm_on_c = (pwm_cnt_q < duty_active_q);
   end

   // Next-state for registers, counters, LED pins and read port.
   always_comb begin
      data_d        = data_q;
      mode_d        = mode_q;
      duty_shadow_d = duty_shadow_q;
      duty_active_d = duty_active_q;
      prescale_d    = prescale_q;
      pre_cnt_d     = pre_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      blink_d       = blink_q;
      leds_d        = '0;
      rdata_d       = '0;
      rvalid_d      = avs_read;

      if (wr_data_c) data_d = avs_writedata[NUM_LEDS-1:0];
      if (wr_set_c)  data_d = data_q | avs_writedata[NUM_LEDS-1:0];
      if (wr_clr_c)  data_d = data_q & ~avs_writedata[NUM_LEDS-1:0];
      if (wr_mode_c) mode_d = avs_writedata[MODE_W-1:0];
      if (wr_duty_c) duty_shadow_d = avs_writedata[PWM_BITS-1:0];
      if (wr_pre_c)  prescale_d = avs_writedata[PRESCALE_W-1:0];

      // A prescale write restarts the count so the new period begins cleanly.
      if (wr_pre_c)    pre_cnt_d = '0;
      else if (tick_c) pre_cnt_d = '0;
      else             pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);

      if (tick_c) pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

      // Duty only changes at the period boundary; a write on that exact edge wins.
      if (wrap_c) begin
         duty_active_d = wr_duty_c ? avs_writedata[PWM_BITS-1:0] : duty_shadow_q;
         blink_d       = ~blink_q;
      end

      for (int i = 0; i < int'(NUM_LEDS); i++) begin
         case (mode_q[2*i +: 2])
            2'b00:   leds_d[i] = data_q[i];
            2'b01:   leds_d[i] = data_q[i] & blink_q;
            2'b10:   leds_d[i] = data_q[i] & pwm_on_c;
            default: leds_d[i] = data_q[i] & blink_q & pwm_on_c;
         endcase
      end

      // Reads sample the register state before any same-cycle write lands.
      if (avs_read) begin
         case (avs_address)
            ADDR_DATA: rdata_d = 32'(data_q);
            ADDR_MODE: rdata_d = 32'(mode_q);
            ADDR_DUTY: rdata_d = 32'(duty_shadow_q);
            ADDR_PRE:  rdata_d = 32'(prescale_q);
            ADDR_LEDS: rdata_d = 32'(leds_q);
            default:   rdata_d = '0;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         data_q        <= '0;
         mode_q        <= '0;
         duty_shadow_q <= '0;
         duty_active_q <= '0;
         prescale_q    <= PRESCALE_W'(DEFAULT_PRESCALE);
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         blink_q       <= 1'b0;
         leds_q        <= '0;
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
      end else begin
         data_q        <= data_d;
         mode_q        <= mode_d;
         duty_shadow_q <= duty_shadow_d;
         duty_active_q <= duty_active_d;
         prescale_q    <= prescale_d;
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_q       <= blink_d;
         leds_q        <= leds_d;
         rdata_q       <= rdata_d;
         rvalid_q      <= rvalid_d;
      end
   end

   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign leds_export       = leds_q;

endmodule

// File: tb/tb_thermo_led_pio.sv
// Bench for thermo_led_pio (NUM_LEDS=10, PWM_BITS=4). Reads are checked by a
// scoreboard queue popped on avs_readdatavalid; LED patterns are sampled on negedge.
module tb_thermo_led_pio;

   localparam int unsigned NL = 10;
   localparam logic [NL-1:0] ALL = 10'h3FF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    addr = '0;
   logic          rd_en = 1'b0;
   logic          wr_en = 1'b0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          rvalid;
   logic [NL-1:0] leds;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] data;
   } exp_t;
   exp_t sb_q[$];

   thermo_led_pio #(
      .NUM_LEDS(NL), .PWM_BITS(4), .PRESCALE_W(16), .DEFAULT_PRESCALE(999)
   ) dut (
      .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd_en),
      .avs_write(wr_en), .avs_writedata(wdata), .avs_readdata(rdata),
      .avs_readdatavalid(rvalid), .leds_export(leds)
   );

   always #5 clk = ~clk;

   // Monitor: every read response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         exp_t e;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: readdatavalid with nothing outstanding, data=%h", rdata);
         end else begin
            e = sb_q.pop_front();
            if (rdata !== e.data) begin
               errors++;
               $display("FAIL rd_addr%0d: got %h expected %h", e.addr, rdata, e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // All tasks enter and leave on a negedge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      addr = a; rd_en = 1'b1;
      sb_q.push_back('{addr: a, data: exp});
      @(negedge clk);
      rd_en = 1'b0;
      check("rd_latency", 32'(rvalid), 32'd1);
   endtask

   task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
      addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b1;
      sb_q.push_back('{addr: a, data: exp});
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      check("rw_latency", 32'(rvalid), 32'd1);
   endtask

   // Advance to the first negedge where leds went from 0 to all-on.
   task automatic find_rise(input string name);
      logic [NL-1:0] prev;
      bit ok = 1'b0;
      prev = leds;
      for (int n = 0; n < 80 && !ok; n++) begin
         @(negedge clk);
         if (prev == '0 && leds == ALL) ok = 1'b1;
         prev = leds;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s: no rising edge within 80 cycles, leds=%h", name, leds);
      end
   endtask

   // Count all-on samples over two consecutive 16-step periods starting at a rise,
   // optionally issuing a DUTY write on sample wr_k.
   task automatic measure(input int wr_k, input logic [31:0] d, output int hi0, output int hi1);
      hi0 = 0; hi1 = 0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) @(negedge clk);
         if (leds == ALL) begin
            if (k < 16) hi0++; else hi1++;
         end
         if (k == wr_k) begin addr = 3'd2; wdata = d; wr_en = 1'b1; end
         else wr_en = 1'b0;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      int h0, h1, bad;

      // Power-on reset.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_rvalid", 32'(rvalid), 32'h0);
      rd(3'd3, 32'd999);
      rd(3'd0, 32'h0);
      rd(3'd1, 32'h0);

      // Static mode: one-cycle write-to-pin latency.
      wr(3'd0, 32'h2A5);
      check("static_latency", 32'(leds), 32'h0);
      @(negedge clk);
      check("static_leds", 32'(leds), 32'h2A5);
      rd(3'd4, 32'h2A5);

      // PWM configuration.
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd4);
      wr(3'd1, 32'hAAAAA);
      wr(3'd0, 32'h3FF);
      repeat (40) @(negedge clk);
      find_rise("pwm_rise");
      measure(-1, 32'd0, h0, h1);
      check("pwm_duty4_p0", 32'(h0), 32'd4);
      check("pwm_duty4_p1", 32'(h1), 32'd4);

      // Mid-period duty write: current period keeps 4, next gets 8.
      find_rise("duty_mid_rise");
      measure(0, 32'd8, h0, h1);
      check("duty_mid_old", 32'(h0), 32'd4);
      check("duty_mid_new", 32'(h1), 32'd8);

      // Duty write landing on the wrap edge loads directly.
      find_rise("duty_wrap_rise");
      measure(14, 32'd2, h0, h1);
      check("duty_wrap_old", 32'(h0), 32'd8);
      check("duty_wrap_new", 32'(h1), 32'd2);

      // Duty 0 is never on.
      wr(3'd2, 32'd0);
      repeat (40) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         if (leds != '0) bad++;
         @(negedge clk);
      end
      check("duty0_const", 32'(bad), 32'd0);
      rd(3'd2, 32'h0);

      // Blink: 16 cycles on, 16 off.
      wr(3'd1, 32'h55555);
      repeat (40) @(negedge clk);
      find_rise("blink_rise");
      bad = 0;
      for (int k = 0; k < 33; k++) begin
         if (k > 0) @(negedge clk);
         if (leds != (((k / 16) % 2 == 0) ? ALL : '0)) bad++;
      end
      check("blink_pattern", 32'(bad), 32'd0);

      // Register map edges.
      wr(3'd1, 32'h0);
      wr(3'd0, 32'hFFFF_FFFF);
      rd(3'd0, 32'h3FF);
      rw(3'd0, 32'h155, 32'h3FF);
      rd(3'd0, 32'h155);
      wr(3'd7, 32'hFFFF);
      rd(3'd7, 32'h0);
      rd(3'd3, 32'h0);

      // Set/clear ports.
      wr(3'd0, 32'h00F);
      wr(3'd5, 32'h300);
`ifdef LED_SET_CLR_EN
      rd(3'd0, 32'h30F);
`else
      rd(3'd0, 32'h00F);
`endif
      rd(3'd5, 32'h0);
      wr(3'd6, 32'h003);
`ifdef LED_SET_CLR_EN
      rd(3'd0, 32'h30C);
`else
      rd(3'd0, 32'h00F);
`endif
      rd(3'd6, 32'h0);

      // Reset mid-blink.
      wr(3'd0, 32'h3FF);
      wr(3'd1, 32'h55555);
      repeat (40) @(negedge clk);
      find_rise("reset_blink_rise");
      repeat (5) @(negedge clk);
      check("pre_reset_leds", 32'(leds), 32'h3FF);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midreset_leds", 32'(leds), 32'h0);
      check("midreset_rvalid", 32'(rvalid), 32'h0);
      rd(3'd3, 32'd999);
      rd(3'd1, 32'h0);
      rd(3'd0, 32'h0);
      rd(3'd4, 32'h0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
